// File: rtl/cpu_mem_pkg.sv
// Shared encodings and default widths for the CPU instruction/data memory arbiter.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 32;

  // One-hot transaction phase of the shared memory port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ISSUE = 3'b010,
    S_WAIT  = 3'b100
  } state_e;

  // Which upstream channel owns the transaction in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/cpu_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 = IF, bit 1 = D.
module rr_arb2
  import cpu_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e last_q, last_d;

  // On a tie the side that was not granted last time wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == OWN_D) ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner only when its request is actually accepted.
  always_comb begin
    last_d = last_q;
    if (advance) begin
      last_d = gnt[1] ? OWN_D : OWN_IF;
    end
  end

  // Last-grant register; resetting to D hands the first tie to IF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch and data channels, one transaction at a time.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  input  logic                if_rsp_ready,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_req_wen,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_rsp_valid,
  input  logic                d_rsp_ready,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_req_wen,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wstrb,
  input  logic                m_rsp_valid,
  output logic                m_rsp_ready,
  input  logic [DATA_W-1:0]   m_rsp_data,
  output logic [CNT_W-1:0]    cnt_if_grant,
  output logic [CNT_W-1:0]    cnt_d_grant,
  output logic [CNT_W-1:0]    cnt_stall,
  output logic                stray_rsp
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_if_q, cnt_if_d;
  logic [CNT_W-1:0]    cnt_d_q, cnt_d_d;
  logic [CNT_W-1:0]    cnt_stall_q, cnt_stall_d;
  logic                stray_q, stray_d;

  logic                is_idle;
  logic                accept;
  logic                owner_rsp_ready;
  logic [1:0]          arb_gnt;

  assign is_idle      = (state_q == S_IDLE);
  assign accept       = is_idle & (if_req_valid | d_req_valid);
  assign if_req_ready = is_idle & arb_gnt[0];
  assign d_req_ready  = is_idle & arb_gnt[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req_valid, if_req_valid}),
    .advance (accept),
    .gnt     (arb_gnt)
  );

  assign owner_rsp_ready = (owner_q == OWN_IF) ? if_rsp_ready : d_rsp_ready;

  // Transaction FSM, request capture and owner-only response steering.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    m_req_valid  = 1'b0;
    m_rsp_ready  = 1'b1;
    if_rsp_valid = 1'b0;
    d_rsp_valid  = 1'b0;
    if_rsp_data  = '0;
    d_rsp_data   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          if (arb_gnt[0]) begin
            owner_d = OWN_IF;
            wen_d   = 1'b0;
            addr_d  = if_req_addr;
            wdata_d = '0;
            wstrb_d = '0;
          end else begin
            owner_d = OWN_D;
            wen_d   = d_req_wen;
            addr_d  = d_req_addr;
            wdata_d = d_req_wdata;
            wstrb_d = d_req_wstrb;
          end
        end
      end
      S_ISSUE: begin
        m_req_valid = 1'b1;
        if (m_req_ready) begin
          state_d = wen_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        m_rsp_ready = owner_rsp_ready;
        if (owner_q == OWN_IF) begin
          if_rsp_valid = m_rsp_valid;
          if_rsp_data  = m_rsp_data;
        end else begin
          d_rsp_valid = m_rsp_valid;
          d_rsp_data  = m_rsp_data;
        end
        if (m_rsp_valid && owner_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant/stall counters and the sticky stray-response flag.
  always_comb begin
    cnt_if_d    = cnt_if_q + CNT_W'(if_req_valid & if_req_ready);
    cnt_d_d     = cnt_d_q + CNT_W'(d_req_valid & d_req_ready);
    cnt_stall_d = cnt_stall_q + CNT_W'((if_req_valid & ~if_req_ready) |
                                       (d_req_valid & ~d_req_ready));
    stray_d     = stray_q | ((state_q != S_WAIT) & m_rsp_valid);
  end

  // State, request register and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_if_q    <= '0;
      cnt_d_q     <= '0;
      cnt_stall_q <= '0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_if_q    <= cnt_if_d;
      cnt_d_q     <= cnt_d_d;
      cnt_stall_q <= cnt_stall_d;
      stray_q     <= stray_d;
    end
  end

  assign m_req_wen    = wen_q;
  assign m_req_addr   = addr_q;
  assign m_req_wdata  = wdata_q;
  assign m_req_wstrb  = wstrb_q;
  assign cnt_if_grant = cnt_if_q;
  assign cnt_d_grant  = cnt_d_q;
  assign cnt_stall    = cnt_stall_q;
  assign stray_rsp    = stray_q;

endmodule
